// File: rtl/regfile_mp_pkg.sv
// Shared register-file constants for decode, writeback and difftest.
// Index 0 is the hardwired-zero register.
package regfile_mp_pkg;
  localparam int RF_XLEN    = 64;
  localparam int RF_REG_NUM = 32;
  localparam int RF_IDX_W   = 5;
  localparam int RF_NR      = 2;
  localparam int RF_NW      = 2;
  localparam int REG_ZERO   = 0;
endpackage

// File: rtl/regfile_mp_if.sv
// Port bundle of the multi-port register file.
// Master is the core pipeline; slave is the register file.
interface regfile_mp_if
  import regfile_mp_pkg::*;
#(
  parameter int XLEN    = RF_XLEN,
  parameter int REG_NUM = RF_REG_NUM,
  parameter int IDX_W   = RF_IDX_W,
  parameter int NR      = RF_NR,
  parameter int NW      = RF_NW
) ();
  logic [NW-1:0]           wr_en;
  logic [NW*IDX_W-1:0]     wr_index;
  logic [NW*XLEN-1:0]      wr_data;
  logic [NR-1:0]           rs_en;
  logic [NR*IDX_W-1:0]     rs_index;
  logic [NR*XLEN-1:0]      rs_data;
  logic [NR-1:0]           rs_busy;
  logic                    sb_set_en;
  logic [IDX_W-1:0]        sb_set_index;
  logic                    flush;
  logic [REG_NUM*XLEN-1:0] regs_o;

  modport master (
    output wr_en, wr_index, wr_data,
    output rs_en, rs_index,
    output sb_set_en, sb_set_index, flush,
    input  rs_data, rs_busy, regs_o
  );

  modport slave (
    input  wr_en, wr_index, wr_data,
    input  rs_en, rs_index,
    input  sb_set_en, sb_set_index, flush,
    output rs_data, rs_busy, regs_o
  );
endinterface

// File: rtl/regfile_wr_arb.sv
// Per-register write hit and winning data from NW write ports.
// Higher port number wins; x0 and out-of-range targets never hit.
module regfile_wr_arb
  import regfile_mp_pkg::*;
#(
  parameter int XLEN    = RF_XLEN,
  parameter int REG_NUM = RF_REG_NUM,
  parameter int IDX_W   = RF_IDX_W,
  parameter int NW      = RF_NW
) (
  input  logic [NW-1:0]       i_en,
  input  logic [NW*IDX_W-1:0] i_index,
  input  logic [NW*XLEN-1:0]  i_data,
  output logic [REG_NUM-1:0]  o_hit,
  output logic [XLEN-1:0]     o_data [REG_NUM]
);

  always_comb begin
    o_hit = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      o_data[i] = '0;
    end
    // ascending scan lets the later (higher) port override
    for (int i = 1; i < REG_NUM; i++) begin
      for (int k = 0; k < NW; k++) begin
        if (i_en[k] &&
            i_index[k*IDX_W +: IDX_W] == IDX_W'(i)) begin
          o_hit[i]  = 1'b1;
          o_data[i] = i_data[k*XLEN +: XLEN];
        end
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with busy scoreboard.
// Exposes the post-write architectural view for difftest.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int XLEN    = RF_XLEN,
  parameter int REG_NUM = RF_REG_NUM,
  parameter int IDX_W   = RF_IDX_W,
  parameter int NR      = RF_NR,
  parameter int NW      = RF_NW,
  parameter int BYPASS  = 1
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);

  localparam bit BYP = (BYPASS != 0);

  logic [XLEN-1:0]         r_regs [1:REG_NUM-1];
  logic [REG_NUM-1:1]      r_busy;

  logic [NW-1:0]           w_wr_en;
  logic [REG_NUM-1:0]      w_hit;
  logic [XLEN-1:0]         w_wdata  [REG_NUM];
  logic [XLEN-1:0]         w_stored [REG_NUM];
  logic [XLEN-1:0]         w_post   [REG_NUM];
  logic [REG_NUM-1:1]      w_busy_nxt;
  logic [NR*XLEN-1:0]      w_rs_data;
  logic [NR-1:0]           w_rs_busy;
  logic [REG_NUM*XLEN-1:0] w_regs;

  // reset cycle ignores writes, so mask them before arbitration
  assign w_wr_en = bus.wr_en & {NW{~rst}};

  regfile_wr_arb #(
    .XLEN    (XLEN),
    .REG_NUM (REG_NUM),
    .IDX_W   (IDX_W),
    .NW      (NW)
  ) u_wr_arb (
    .i_en    (w_wr_en),
    .i_index (bus.wr_index),
    .i_data  (bus.wr_data),
    .o_hit   (w_hit),
    .o_data  (w_wdata)
  );

  always_comb begin
    w_stored[REG_ZERO] = '0;
    for (int i = 1; i < REG_NUM; i++) begin
      w_stored[i] = r_regs[i];
    end
    for (int i = 0; i < REG_NUM; i++) begin
      w_post[i] = w_hit[i] ? w_wdata[i] : w_stored[i];
    end
  end

  // new producer beats same-cycle writeback; flush beats both
  always_comb begin
    w_busy_nxt = r_busy;
    for (int i = 1; i < REG_NUM; i++) begin
      if (bus.sb_set_en &&
          bus.sb_set_index == IDX_W'(i)) begin
        w_busy_nxt[i] = 1'b1;
      end else if (w_hit[i]) begin
        w_busy_nxt[i] = 1'b0;
      end
    end
    if (bus.flush) begin
      w_busy_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < REG_NUM; i++) begin
        r_regs[i] <= '0;
      end
      r_busy <= '0;
    end else begin
      for (int i = 1; i < REG_NUM; i++) begin
        if (w_hit[i]) begin
          r_regs[i] <= w_wdata[i];
        end
      end
      r_busy <= w_busy_nxt;
    end
  end

  always_comb begin
    w_rs_data = '0;
    w_rs_busy = '0;
    for (int p = 0; p < NR; p++) begin
      for (int i = 1; i < REG_NUM; i++) begin
        if (bus.rs_en[p] && !rst &&
            bus.rs_index[p*IDX_W +: IDX_W] == IDX_W'(i)) begin
          w_rs_data[p*XLEN +: XLEN] =
            BYP ? w_post[i] : w_stored[i];
          w_rs_busy[p] = r_busy[i] & ~(BYP & w_hit[i]);
        end
      end
    end
  end

  always_comb begin
    w_regs = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      w_regs[i*XLEN +: XLEN] = rst ? '0 : w_post[i];
    end
  end

  assign bus.rs_data = w_rs_data;
  assign bus.rs_busy = w_rs_busy;
  assign bus.regs_o  = w_regs;

endmodule

// File: tb/tb_regfile_mp.sv
// Drives BYPASS=1 and BYPASS=0 register files in lockstep
// against a queue of predicted outputs.
module tb_regfile_mp;
  import regfile_mp_pkg::*;

  localparam int XL = 64;
  localparam int RN = 28;
  localparam int IW = 5;
  localparam int NR = 2;
  localparam int NW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_mp_if #(.XLEN(XL), .REG_NUM(RN), .IDX_W(IW),
                  .NR(NR), .NW(NW)) if1 ();
  regfile_mp_if #(.XLEN(XL), .REG_NUM(RN), .IDX_W(IW),
                  .NR(NR), .NW(NW)) if0 ();

  regfile_mp #(.XLEN(XL), .REG_NUM(RN), .IDX_W(IW), .NR(NR),
               .NW(NW), .BYPASS(1)) u_byp (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  regfile_mp #(.XLEN(XL), .REG_NUM(RN), .IDX_W(IW), .NR(NR),
               .NW(NW), .BYPASS(0)) u_nob (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  logic [NW-1:0] s_wen;
  logic [IW-1:0] s_widx [NW];
  logic [XL-1:0] s_wdat [NW];
  logic [NR-1:0] s_ren;
  logic [IW-1:0] s_ridx [NR];
  logic          s_set;
  logic [IW-1:0] s_setidx;
  logic          s_flush;

  logic [XL-1:0] m_regs [RN];
  bit            m_busy [RN];
  bit            m_hit  [RN];
  logic [XL-1:0] m_wv   [RN];

  typedef struct packed {
    logic [NR*XL-1:0] d1;
    logic [NR*XL-1:0] d0;
    logic [NR-1:0]    b1;
    logic [NR-1:0]    b0;
    logic [RN*XL-1:0] regs;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   errs = 0;
  int   nchk = 0;

  task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
    nchk++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", nm, a, e);
    end
  endtask

  task automatic idle();
    s_wen = '0;
    s_ren = '0;
    s_set = 1'b0;
    s_flush = 1'b0;
    s_setidx = '0;
    for (int k = 0; k < NW; k++) begin
      s_widx[k] = '0;
      s_wdat[k] = '0;
    end
    for (int p = 0; p < NR; p++) s_ridx[p] = '0;
  endtask

  task automatic wr(int k, int idx, logic [XL-1:0] d);
    s_wen[k]  = 1'b1;
    s_widx[k] = IW'(idx);
    s_wdat[k] = d;
  endtask

  task automatic rd(int p, int idx);
    s_ren[p]  = 1'b1;
    s_ridx[p] = IW'(idx);
  endtask

  task automatic drive();
    if1.wr_en = s_wen;
    if0.wr_en = s_wen;
    for (int k = 0; k < NW; k++) begin
      if1.wr_index[k*IW +: IW] = s_widx[k];
      if0.wr_index[k*IW +: IW] = s_widx[k];
      if1.wr_data[k*XL +: XL]  = s_wdat[k];
      if0.wr_data[k*XL +: XL]  = s_wdat[k];
    end
    if1.rs_en = s_ren;
    if0.rs_en = s_ren;
    for (int p = 0; p < NR; p++) begin
      if1.rs_index[p*IW +: IW] = s_ridx[p];
      if0.rs_index[p*IW +: IW] = s_ridx[p];
    end
    if1.sb_set_en = s_set;
    if0.sb_set_en = s_set;
    if1.sb_set_index = s_setidx;
    if0.sb_set_index = s_setidx;
    if1.flush = s_flush;
    if0.flush = s_flush;
  endtask

  // which registers this cycle's writes land on, last port wins
  task automatic resolve();
    for (int i = 0; i < RN; i++) begin
      m_hit[i] = 1'b0;
      m_wv[i]  = '0;
    end
    if (!rst) begin
      for (int k = 0; k < NW; k++) begin
        int idx = int'(s_widx[k]);
        if (s_wen[k] && idx > 0 && idx < RN) begin
          m_hit[idx] = 1'b1;
          m_wv[idx]  = s_wdat[k];
        end
      end
    end
  endtask

  function automatic exp_t predict();
    exp_t e;
    e = '0;
    for (int i = 1; i < RN; i++) begin
      if (!rst) e.regs[i*XL +: XL] = m_hit[i] ? m_wv[i] : m_regs[i];
    end
    for (int p = 0; p < NR; p++) begin
      int idx = int'(s_ridx[p]);
      if (!rst && s_ren[p] && idx > 0 && idx < RN) begin
        e.d1[p*XL +: XL] = m_hit[idx] ? m_wv[idx] : m_regs[idx];
        e.d0[p*XL +: XL] = m_regs[idx];
        e.b1[p] = m_busy[idx] && !m_hit[idx];
        e.b0[p] = m_busy[idx];
      end
    end
    return e;
  endfunction

  task automatic model_update();
    if (rst) begin
      for (int i = 0; i < RN; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      for (int i = 1; i < RN; i++) begin
        if (m_hit[i]) begin
          m_regs[i] = m_wv[i];
          m_busy[i] = 1'b0;
        end
      end
      if (s_set && s_setidx > 0 && int'(s_setidx) < RN)
        m_busy[s_setidx] = 1'b1;
      if (s_flush)
        for (int i = 0; i < RN; i++) m_busy[i] = 1'b0;
    end
  endtask

  task automatic step();
    drive();
    resolve();
    q.push_back(predict());
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic peek_reg(string nm, int idx, logic [XL-1:0] e);
    idle();
    drive();
    #1;
    chk({nm, "_b1"}, if1.regs_o[idx*XL +: XL], e);
    chk({nm, "_b0"}, if0.regs_o[idx*XL +: XL], e);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      m_e = q.pop_front();
      for (int p = 0; p < NR; p++) begin
        chk($sformatf("rd%0d_b1", p), if1.rs_data[p*XL +: XL],
            m_e.d1[p*XL +: XL]);
        chk($sformatf("rd%0d_b0", p), if0.rs_data[p*XL +: XL],
            m_e.d0[p*XL +: XL]);
      end
      chk("busy_b1", 64'(if1.rs_busy), 64'(m_e.b1));
      chk("busy_b0", 64'(if0.rs_busy), 64'(m_e.b0));
      for (int i = 0; i < RN; i++) begin
        chk($sformatf("regs%0d_b1", i), if1.regs_o[i*XL +: XL],
            m_e.regs[i*XL +: XL]);
        chk($sformatf("regs%0d_b0", i), if0.regs_o[i*XL +: XL],
            m_e.regs[i*XL +: XL]);
      end
    end
  end

  initial begin
    for (int i = 0; i < RN; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    rst = 1'b1;
    idle();
    drive();
    @(posedge clk);
    #1;
    // reset then read
    rd(0, 0); rd(1, 3);
    step(); step();
    rst = 1'b0;
    step();
    // write conflict and x0 write
    idle(); wr(0, 5, 64'hAA); wr(1, 5, 64'hBB); rd(0, 5);
    step();
    peek_reg("x5_conflict", 5, 64'hBB);
    idle(); wr(0, 0, 64'h1); rd(0, 0); rd(1, 5);
    step();
    idle(); rd(0, 0);
    step();
    // same-cycle bypass
    idle(); wr(0, 7, 64'h1234); rd(0, 7);
    step();
    idle(); rd(0, 7);
    step();
    // scoreboard lifecycle
    idle(); s_set = 1'b1; s_setidx = 5'd9;
    step();
    idle(); rd(0, 9);
    step();
    idle(); wr(1, 9, 64'h99); rd(0, 9);
    step();
    idle(); rd(0, 9);
    step();
    // set/clear collision
    idle(); s_set = 1'b1; s_setidx = 5'd4; wr(0, 4, 64'h44);
    step();
    peek_reg("x4_data", 4, 64'h44);
    idle(); rd(1, 4);
    drive();
    #1;
    chk("x4_busy_b1", 64'(if1.rs_busy[1]), 64'd1);
    step();
    // flush drops in-flight and same-cycle producers
    idle(); s_set = 1'b1; s_setidx = 5'd2;
    step();
    idle(); s_set = 1'b1; s_setidx = 5'd3; rd(0, 2);
    step();
    idle(); s_set = 1'b1; s_setidx = 5'd6; s_flush = 1'b1;
    rd(0, 2); rd(1, 3);
    step();
    idle(); rd(0, 6); rd(1, 3);
    step();
    // reset wins over a concurrent write
    idle(); wr(0, 8, 64'hFF); rst = 1'b1;
    step();
    rst = 1'b0;
    peek_reg("x8_rst", 8, 64'h0);
    idle(); rd(0, 8);
    step();
    // out-of-range targets are dropped
    idle(); wr(0, 30, 64'h3); rd(0, 30); s_set = 1'b1; s_setidx = 5'd29;
    step();
    for (int n = 0; n < 400; n++) begin
      idle();
      rst = ($urandom_range(0, 49) == 0);
      for (int k = 0; k < NW; k++) begin
        if ($urandom_range(0, 1) == 1)
          wr(k, int'($urandom_range(0, 31)), {$urandom, $urandom});
      end
      for (int p = 0; p < NR; p++) begin
        s_ren[p]  = 1'($urandom_range(0, 1));
        s_ridx[p] = IW'($urandom_range(0, 31));
      end
      s_set    = ($urandom_range(0, 2) == 0);
      s_setidx = IW'($urandom_range(0, 31));
      s_flush  = ($urandom_range(0, 19) == 0);
      step();
    end
    rst = 1'b0;
    idle();
    drive();
    repeat (2) @(negedge clk);
    nchk++;
    if (q.size() != 0) begin
      errs++;
      $display("FAIL drain got=%0d exp=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file. It is the next generation of the single-write, dual-read core register file. It adds N read ports, M write ports with fixed priority, optional same-cycle write-to-read bypass, and a per-register busy scoreboard for in-flight producers. It sits in decode/writeback of the pipelined core and exports the architectural state view for difftest.

Parameters:
XLEN, 64, register data width in bits
REG_NUM, 32, number of architectural registers; x0 hardwired to zero
IDX_W, 5, register index width; must satisfy 2**IDX_W >= REG_NUM
NR, 2, number of read ports
NW, 2, number of write ports; a higher port number has higher priority
BYPASS, 1, 1 = reads and busy lookups see same-cycle writes; 0 = registered state only

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
wr_en  in  NW  per-port write enable
wr_index  in  NW*IDX_W  per-port destination index; port k occupies bits [k*IDX_W +: IDX_W]
wr_data  in  NW*XLEN  per-port write data
rs_en  in  NR  per-port read enable
rs_index  in  NR*IDX_W  per-port source index
rs_data  out  NR*XLEN  per-port read data (combinational)
rs_busy  out  NR  source has an outstanding producer (combinational)
sb_set_en  in  1  issue of an instruction with a destination register
sb_set_index  in  IDX_W  destination index being issued
flush  in  1  squash all in-flight producers
regs_o  out  REG_NUM*XLEN  difftest view, post-write (combinational)

Behaviour:
- Reset (clk edge with rst=1): all registers 1..REG_NUM-1 become 0 and all busy bits become 0. All other inputs are ignored that cycle.
- Outputs during and right after reset: rs_data=0, rs_busy=0, regs_o all 0.
- Writes: register i is updated at the edge when any enabled port has wr_index==i.
  - When several ports target i, the highest-numbered enabled port wins.
  - Writes to x0 and to indices >= REG_NUM are dropped.
- Reads, with zero-cycle latency:
  - rs_data[p] = 0 if rs_en[p]=0, or the index is 0, or the index is >= REG_NUM.
  - Otherwise, with BYPASS=1 and a same-cycle enabled write to that index, rs_data[p] is the winning write's data.
  - Otherwise rs_data[p] is the stored value.
- regs_o[i] always shows the post-write value: the winning same-cycle write if any, else stored; regs_o[0]=0. This holds independent of BYPASS.
- Scoreboard busy[1..REG_NUM-1], next-state priority per bit:
  1. rst clears the bit.
  2. flush clears the bit; a sb_set in the same cycle is also dropped.
  3. sb_set_en with sb_set_index==i sets the bit. A new producer overrides a same-cycle writeback clear to the same index.
  4. An enabled write to i clears the bit.
  5. Otherwise the bit holds.
  - sb_set to x0 or an out-of-range index is ignored.
- rs_busy[p] = rs_en[p] & (index!=0) & busy[index] & ~(BYPASS & same-cycle write hit on index).
  - The mask means that with BYPASS=1 a consumer sees the data and a non-busy flag in the writeback cycle.
  - With BYPASS=0 the consumer sees busy until the cycle after writeback.
- Writes are accepted regardless of busy state; the scoreboard is advisory.
- No combinational path from rs_* to any other output except its own port.

Decomposition:
- Shared defines header: XLEN, REG_NUM, IDX_W and REG_ZERO, reused by decode and difftest.
- One natural sub-module, regfile_wr_arb: given NW enables, indices and data, it returns per-register hit and winning data via a priority select. The storage array, bypass and regs_o all use its outputs.
- The scoreboard stays inline.

Test Plan:
- Reset then read: rst=1 for 2 cycles, then rs_en=11, rs_index={3,0} -> rs_data={0,0}, rs_busy=00, regs_o all 0.
- Write conflict: wr_en=11, wr_index={5,5}, wr_data={port0 0xAA, port1 0xBB} -> next cycle x5=0xBB; a write to x0 with 0x1 -> x0 reads 0.
- Bypass: BYPASS=1, write x7=0x1234 and read x7 in the same cycle -> rs_data=0x1234. BYPASS=0, same stimulus -> old value 0, and 0x1234 the following cycle.
- Scoreboard lifecycle: sb_set x9 -> the next cycle rs_busy on x9 = 1. Writeback x9 with BYPASS=1 -> rs_busy=0 in that same cycle; with BYPASS=0 -> rs_busy=0 from the next cycle.
- Set/clear collision: sb_set x4 and wr x4 in the same cycle -> busy[4]=1 afterwards, and x4 data is updated.
- Flush and reset mid-op: busy on x2, x3; flush with sb_set x6 -> all busy 0 next cycle. rst asserted while wr_en=1 on x8=0xFF -> x8=0.
